alu_unit: RTL and testbench
===========================

# alu_unit

Registered, handshaked successor to the combinational `alu`. It keeps the zx/nx/zy/ny/f/no datapath and adds a carry-in for multi-precision chaining and an optional multi-cycle unsigned multiply. All outputs are registered behind a valid/ready handshake. It sits between the decode stage and the register-file writeback of the CPU.

## Interface
- BUS_WIDTH, 16, operand/result width; must be at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- mode  in  1  0 = logic/add (Hack control bits), 1 = multiply.
- zx, nx, zy, ny, f, no  in  1 each  Hack control bits; ignored in multiply mode.
- cin  in  1  carry-in added when f=1; ignored otherwise.
- x, y  in  BUS_WIDTH  operands.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- out  out  BUS_WIDTH  result (low half of product in multiply mode).
- out_hi  out  BUS_WIDTH  high half of product; 0 in mode 0.
- carry, zr, ng  out  1 each  flags.

## Operation
- Mode 0 datapath:
  - x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1. y2 is formed from y the same way using zy/ny.
  - r = f ? x2 + y2 + cin : x2 & y2. The sum is BUS_WIDTH+1 bits wide.
  - carry = f ? sum[BUS_WIDTH] : 0. Carry is taken before the no inversion.
  - out = no ? ~r : r.
- Mode 1: unsigned x*y, {out_hi,out} = 2*BUS_WIDTH-bit product, computed by radix-2 shift-add, one partial product per cycle.
  - zr = product == 0.
  - ng = out_hi[BUS_WIDTH-1].
  - carry = (out_hi != 0).
- Mode 0 flags: zr = (out == 0); ng = out[BUS_WIDTH-1].
- FSM states:
  - IDLE: accepts requests.
  - MUL: runs BUS_WIDTH iterations using a counter.
  - Result holding is tracked by out_valid, independent of the state.
- Transitions:
  - IDLE to MUL on an accepted mode-1 request.
  - MUL to IDLE after the BUS_WIDTH-th iteration; out_valid is set on that edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A result being drained and a new mode-0 request may be accepted in the same cycle.
- out_valid clears on the out_ready handshake unless a new result is loaded on the same edge.
- All result and flag registers hold their values while out_valid=1 and out_ready=0.
- Operands are latched at acceptance; input changes after that have no effect.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; out_valid=0; out, out_hi, carry, zr, ng all 0. in_ready is 1 in the first cycle after release.
- Mode 0: request accepted at edge N; out_valid=1 after edge N+1. Throughput is one per cycle under no backpressure.
- Mode 1: accepted at edge N; out_valid=1 after edge N+BUS_WIDTH. in_ready=0 throughout MUL.
- Reset during MUL aborts the operation; no partial result ever becomes visible.
- in_valid while in_ready=0 is ignored. The requester holds its request; the unit does not latch it.

## Configuration
- ALU_UNIT_MUL_EN defined: multiply mode, the MUL state and the iteration counter are present.
- ALU_UNIT_MUL_EN undefined: mode is ignored and every request executes as mode 0 with 1-cycle latency; out_hi is tied to 0. The port list is unchanged.

## Structure
- Package alu_pkg holds:
  - MODE_LOGIC and MODE_MUL constants.
  - FSM state typedef (IDLE, MUL).
  - Default BUS_WIDTH constant.
- Sub-module alu_core holds the combinational Hack datapath with cin. It outputs r_out, carry, zr and ng, and is instantiated once in front of the result registers.
- The multiplier accumulator and counter live in alu_unit, under the macro.

## Test plan
- x=1, y=3, f=0, mode 0: out=0x0001, carry=0, zr=0, ng=0; out_valid exactly one cycle after acceptance.
- x=0xFFFF, y=0x0001, f=1, cin=0: out=0x0000, carry=1, zr=1. Chained next op x=0, y=0, f=1, cin=1: out=0x0001, carry=0.
- x=1, y=3, f=1, no=1: out=0xFFFB, ng=1, carry=0. Also nx=ny=1, f=0: out=0xFFFC.
- mode 1, x=300, y=300: out=0x5F90, out_hi=0x0001, carry=1, zr=0; out_valid 16 cycles after acceptance; in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles after a result, with a second mode-0 request pending. Result and flags are stable and in_ready=0; the second request is accepted in the cycle out_ready rises, and its result appears on the next cycle.
- rst_n asserted on the 5th MUL cycle: out_valid=0 and all outputs 0 immediately; in_ready=1 after release; no stale product is ever presented.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the registered ALU unit.
// Multiply support is selected by the ALU_UNIT_MUL_EN macro in alu_unit.
package alu_pkg;

    localparam int BUS_WIDTH_DEFAULT = 16;

    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_MUL   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack ALU datapath (zx/nx/zy/ny/f/no) extended with a carry-in.
// Feeds the result registers of alu_unit.
module alu_core
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT
) (
    input  logic [BUS_WIDTH-1:0] x,
    input  logic [BUS_WIDTH-1:0] y,
    input  logic                 zx,
    input  logic                 nx,
    input  logic                 zy,
    input  logic                 ny,
    input  logic                 f,
    input  logic                 no,
    input  logic                 cin,
    output logic [BUS_WIDTH-1:0] r_out,
    output logic                 carry,
    output logic                 zr,
    output logic                 ng
);

    logic [BUS_WIDTH-1:0] x1, x2, y1, y2, r;
    logic [BUS_WIDTH:0]   sum;

    always_comb begin
        x1    = zx ? '0 : x;
        x2    = nx ? ~x1 : x1;
        y1    = zy ? '0 : y;
        y2    = ny ? ~y1 : y1;
        sum   = {1'b0, x2} + {1'b0, y2} + {{BUS_WIDTH{1'b0}}, cin};
        r     = f ? sum[BUS_WIDTH-1:0] : (x2 & y2);
        // Carry comes from the adder, before the optional output inversion.
        carry = f & sum[BUS_WIDTH];
        r_out = no ? ~r : r;
        zr    = (r_out == '0);
        ng    = r_out[BUS_WIDTH-1];
    end

endmodule

// File: rtl/alu_unit.sv
// Registered, valid/ready-handshaked ALU with carry-in and, when ALU_UNIT_MUL_EN
// is defined, a radix-2 shift-add unsigned multiplier (one partial product per cycle).
module alu_unit
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic                 zx,
    input  logic                 nx,
    input  logic                 zy,
    input  logic                 ny,
    input  logic                 f,
    input  logic                 no,
    input  logic                 cin,
    input  logic [BUS_WIDTH-1:0] x,
    input  logic [BUS_WIDTH-1:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out,
    output logic [BUS_WIDTH-1:0] out_hi,
    output logic                 carry,
    output logic                 zr,
    output logic                 ng
);

    state_t                 state, state_next;
    logic                   accept, load_logic, mul_done;
    logic [2*BUS_WIDTH-1:0] mul_res;
    logic [BUS_WIDTH-1:0]   core_r;
    logic                   core_carry, core_zr, core_ng;

    alu_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .cin(cin),
        .r_out(core_r), .carry(core_carry), .zr(core_zr), .ng(core_ng)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // Requests transfer on in_valid/in_ready, results on out_valid/out_ready; a held
    // result frees its slot in the same cycle it is drained.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_UNIT_MUL_EN
    localparam int CNT_W = $clog2(BUS_WIDTH);

    logic [BUS_WIDTH-1:0] mcand, p_hi, p_lo, src_hi, src_lo, src_mc;
    logic [BUS_WIDTH:0]   step_sum;
    logic [CNT_W-1:0]     cnt;
    logic                 start_mul;

    assign start_mul  = accept && (mode == MODE_MUL);
    assign load_logic = accept && (mode == MODE_LOGIC);
    assign mul_done   = (state == MUL) && (cnt == CNT_W'(BUS_WIDTH - 1));

    // The accepting edge already applies the first partial product from x/y directly.
    always_comb begin
        src_hi   = (state == MUL) ? p_hi  : '0;
        src_lo   = (state == MUL) ? p_lo  : y;
        src_mc   = (state == MUL) ? mcand : x;
        step_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mc} : '0);
        mul_res  = {step_sum, src_lo[BUS_WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
        end else if (start_mul) begin
            mcand        <= x;
            {p_hi, p_lo} <= mul_res;
            cnt          <= CNT_W'(1);
        end else if (state == MUL) begin
            {p_hi, p_lo} <= mul_res;
            cnt          <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign load_logic  = accept;
    assign mul_done    = 1'b0;
    assign mul_res     = '0;

    always_comb begin
        state_next = IDLE;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       out_valid <= 1'b0;
        else if (load_logic || mul_done)  out_valid <= 1'b1;
        else if (out_ready)               out_valid <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            out_hi <= '0;
            carry  <= 1'b0;
            zr     <= 1'b0;
            ng     <= 1'b0;
        end else if (load_logic) begin
            out    <= core_r;
            out_hi <= '0;
            carry  <= core_carry;
            zr     <= core_zr;
            ng     <= core_ng;
        end else if (mul_done) begin
            out    <= mul_res[BUS_WIDTH-1:0];
            out_hi <= mul_res[2*BUS_WIDTH-1:BUS_WIDTH];
            carry  <= |mul_res[2*BUS_WIDTH-1:BUS_WIDTH];
            zr     <= (mul_res == '0);
            ng     <= mul_res[2*BUS_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit with a result scoreboard; adapts multiply
// expectations to whether ALU_UNIT_MUL_EN is defined.
module tb_alu_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, mode;
    logic         zx, nx, zy, ny, f, no, cin;
    logic [W-1:0] x, y, out, out_hi;
    logic         out_valid, out_ready, carry, zr, ng;

    logic [2*W+2:0] exp_q[$];
    logic [2*W+2:0] sb_exp;
    int checks   = 0;
    int failures = 0;

    alu_unit #(.BUS_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .cin(cin), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_hi(out_hi),
        .carry(carry), .zr(zr), .ng(ng)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W+2:0] model(input logic m, input logic [5:0] ctl,
                                             input logic c_in, input logic [W-1:0] a, b);
        logic [W-1:0]   a1, b1, r;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic           c;
`ifdef ALU_UNIT_MUL_EN
        if (m) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return {p, (p[2*W-1:W] != 0), (p == 0), p[2*W-1]};
        end
`else
        p = {2*W{m}};
`endif
        a1 = ctl[5] ? '0 : a;
        if (ctl[4]) a1 = ~a1;
        b1 = ctl[3] ? '0 : b;
        if (ctl[2]) b1 = ~b1;
        s = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, c_in};
        r = ctl[1] ? s[W-1:0] : (a1 & b1);
        c = ctl[1] & s[W];
        if (ctl[0]) r = ~r;
        return {p[2*W-1:W] & '0, r, c, (r == 0), r[W-1]};
    endfunction

    // Drive one request, wait (bounded) for acceptance, push its expectation,
    // then scramble the operands to show they were latched.
    task automatic req(input logic m, input logic [5:0] ctl, input logic c_in,
                       input logic [W-1:0] a, b, input logic [2*W+2:0] e);
        bit ok = 0;
        mode = m; {zx, nx, zy, ny, f, no} = ctl; cin = c_in; x = a; y = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                exp_q.push_back(e);
            end
        end
        chk("accept", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = W'($urandom); y = W'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_unexpected observed=0x%0h expected=none", {out_hi, out, carry, zr, ng});
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_result", {out_hi, out, carry, zr, ng}, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2*W+2:0] exp_mul, e;
        logic [5:0]     ctl;
        logic [W-1:0]   a, b;
        logic           c_in, stale;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        {zx, nx, zy, ny, f, no} = '0; cin = 1'b0; x = '0; y = '0;
`ifdef ALU_UNIT_MUL_EN
        exp_mul = {16'h0001, 16'h5F90, 3'b100};
`else
        exp_mul = {16'h0000, 16'h012C, 3'b000};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_outputs", {out_hi, out, carry, zr, ng}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        req(0, 6'b000000, 0, 16'd1, 16'd3, {16'h0, 16'h0001, 3'b000});
        @(negedge clk);
        chk("and_latency", out_valid, 1);
        @(posedge clk); #1;

        req(0, 6'b000010, 0, 16'hFFFF, 16'h0001, {16'h0, 16'h0000, 3'b110});
        req(0, 6'b000010, 1, 16'h0000, 16'h0000, {16'h0, 16'h0001, 3'b000});
        req(0, 6'b000011, 0, 16'd1, 16'd3, {16'h0, 16'hFFFB, 3'b001});
        req(0, 6'b010100, 0, 16'd1, 16'd3, {16'h0, 16'hFFFC, 3'b001});

        req(1, 6'b000000, 0, 16'd300, 16'd300, exp_mul);
`ifdef ALU_UNIT_MUL_EN
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_valid", out_valid, 0);
            chk("mul_busy_ready", in_ready, 0);
        end
`endif
        @(negedge clk);
        chk("mul_latency", out_valid, 1);
        @(posedge clk); #1;

        // Back-to-back random mode-0 traffic.
        for (int i = 0; i < 12; i++) begin
            ctl = 6'($urandom_range(0, 63)); c_in = 1'($urandom_range(0, 1));
            a = W'($urandom_range(0, 65535)); b = W'($urandom_range(0, 65535));
            mode = 1'b0; {zx, nx, zy, ny, f, no} = ctl; cin = c_in; x = a; y = b;
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", in_ready, 1);
            exp_q.push_back(model(0, ctl, c_in, a, b));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure with a second request pending.
        out_ready = 1'b0;
        req(0, 6'b000010, 0, 16'd5, 16'd6, {16'h0, 16'h000B, 3'b000});
        mode = 1'b0; {zx, nx, zy, ny, f, no} = 6'b000010; cin = 1'b0; x = 16'd7; y = 16'd8;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", {out_hi, out, carry, zr, ng}, {16'h0, 16'h000B, 3'b000});
            chk("bp_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", in_ready, 1);
        exp_q.push_back({16'h0, 16'h000F, 3'b000});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_out", out, 16'h000F);
        @(posedge clk); #1;

        // Reset in the 5th multiply cycle.
        req(1, 6'b000000, 0, 16'd300, 16'd300, exp_mul);
        repeat (4) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_outputs", {out_hi, out, carry, zr, ng}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        stale = 1'b0;
        repeat (20) begin
            @(negedge clk);
            stale = stale | out_valid;
        end
        chk("abort_no_stale", stale, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
